// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver for the host serial link.
// Two-FF input synchroniser, mid-bit sampling, start-glitch rejection,
// framing and overrun detection, one-word valid/ready output buffer.
// Optional parity checking is built when UART_RX_PARITY_EN is defined;
// without it the frame is start, DATA_BITS, stop and parity_err_o is 0.
//
// state    | meaning
// ---------+--------------------------------------------------------
// S_IDLE   | line idle, waiting for a low level on rx_s
// S_START  | timing to the middle of the start bit, re-checking it
// S_DATA   | sampling DATA_BITS data bits, LSB first
// S_PARITY | sampling the parity bit (UART_RX_PARITY_EN only)
// S_STOP   | sampling the stop bit, delivering or rejecting the word
// S_BRK    | stop bit was low; waiting for the line to return high
module uart_rx_param #(
    parameter int CLK_HZ     = 48000000,
    parameter int BAUD       = 57600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 overrun_o,
    input  logic                 overrun_clr_i,
    output logic                 busy_o
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    // Reject parameter sets the datapath was not sized for.
    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY_ODD < 0 || PARITY_ODD > 1 ||
        CLKS_PER_BIT < 4) begin : g_bad_param
        $error("uart_rx_param: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BRK
    } state_t;

    state_t                 state;
    logic                   rx_meta;
    logic                   rx_s;
    logic [CNT_W-1:0]       cnt;
    logic [IDX_W-1:0]       idx;
    logic [DATA_BITS-1:0]   shift;
    logic                   par_ok;
    logic                   deliver;

`ifdef UART_RX_PARITY_EN
    logic                   par_bit;

    // Data plus parity bit must have the configured overall sense.
    assign par_ok = (^shift ^ par_bit) == (PARITY_ODD != 0);
`else
    assign par_ok       = 1'b1;
    assign parity_err_o = 1'b0;
`endif

    // A word is handed over only on a good stop bit with good parity.
    assign deliver = (state == S_STOP) && (cnt == CNT_FULL) && rx_s && par_ok;
    assign busy_o  = (state != S_IDLE);

    // Two-FF synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    // Receive FSM with output buffer, error pulses and sticky overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            idx         <= '0;
            shift       <= '0;
            rx_data_o   <= '0;
            rx_valid_o  <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit      <= 1'b0;
            parity_err_o <= 1'b0;
`endif
        end else begin
            frame_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_o <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (!rx_s) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt   <= '0;
                        state <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == CNT_FULL) begin
                        cnt   <= '0;
                        // LSB arrives first, so shift right from the top.
                        shift <= {rx_s, shift[DATA_BITS-1:1]};
                        if (idx == IDX_LAST) begin
                            idx <= '0;
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt == CNT_FULL) begin
                        cnt     <= '0;
                        par_bit <= rx_s;
                        state   <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt == CNT_FULL) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= S_IDLE;
`ifdef UART_RX_PARITY_EN
                            parity_err_o <= !par_ok;
`endif
                        end else begin
                            frame_err_o <= 1'b1;
                            state       <= S_BRK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_BRK: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Clear first so that a same-cycle overrun set takes priority.
            if (overrun_clr_i) begin
                overrun_o <= 1'b0;
            end

            if (deliver) begin
                if (!rx_valid_o || rx_ready_i) begin
                    rx_data_o  <= shift;
                    rx_valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (rx_valid_o && rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end
        end
    end

endmodule
